alu_exec_unit: RTL and testbench

//   Execution-side consumer of the alu_control_t code produced by the ALU decoder.

---
 rtl/alu_exec_unit_if.sv | 40 ++++
 rtl/alu_exec_unit.sv | 124 ++++++++++++
 tb/tb_alu_exec_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operation-code package and request/result handshake interface for alu_exec_unit.
// The package sits here so that the interface and the execution unit share one alu_control_t.
package alu_exec_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_XOR = 4'd2,
        ALU_OR  = 4'd3,
        ALU_AND = 4'd4,
        ALU_SLT = 4'd5,
        ALU_A   = 4'd6,
        ALU_B   = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9
    } alu_control_t;
endpackage

interface alu_exec_unit_if #(parameter int WIDTH = 32);
    import alu_exec_pkg::*;

    logic             valid_i;
    logic             ready_o;
    alu_control_t     alu_control_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;

    modport master (
        output valid_i, alu_control_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o
    );

    modport slave (
        input  valid_i, alu_control_i, a_i, b_i, ready_i,
        output ready_o, valid_o, result_o, zero_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: one op per request, registered result and zero flag, iterative 1-bit/cycle shifts.
// Define ALU_FAST_SHIFT_EN to make shifts single-cycle (no SHIFT state, no counter).
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_value;

`ifndef ALU_FAST_SHIFT_EN
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic             left_reg, left_next;
    logic             is_shift;
`endif

    assign shamt = bus.b_i[SHW-1:0];

    // Full single-cycle function; the iterative build only uses its shift arms when shamt is zero.
    always_comb begin
        alu_value = bus.a_i;
        case (bus.alu_control_i)
            ALU_ADD: alu_value = bus.a_i + bus.b_i;
            ALU_SUB: alu_value = bus.a_i - bus.b_i;
            ALU_XOR: alu_value = bus.a_i ^ bus.b_i;
            ALU_OR:  alu_value = bus.a_i | bus.b_i;
            ALU_AND: alu_value = bus.a_i & bus.b_i;
            ALU_SLT: alu_value = {{(WIDTH-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
            ALU_A:   alu_value = bus.a_i;
            ALU_B:   alu_value = bus.b_i;
            ALU_SLL: alu_value = bus.a_i << shamt;
            ALU_SRL: alu_value = bus.a_i >> shamt;
            default: alu_value = bus.a_i;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    assign is_shift = (bus.alu_control_i == ALU_SLL) || (bus.alu_control_i == ALU_SRL);
`endif

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
`ifndef ALU_FAST_SHIFT_EN
        cnt_next    = cnt_reg;
        left_next   = left_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.valid_i) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        result_next = bus.a_i;
                        cnt_next    = shamt;
                        left_next   = (bus.alu_control_i == ALU_SLL);
                        state_next  = SHIFT;
                    end else begin
                        result_next = alu_value;
                        state_next  = DONE;
                    end
`else
                    result_next = alu_value;
                    state_next  = DONE;
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                result_next = left_reg ? (result_reg << 1) : (result_reg >> 1);
                cnt_next    = cnt_reg - 1'b1;
                if (cnt_reg == SHW'(1)) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
            cnt_reg    <= '0;
            left_reg   <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= (result_next == '0);
`ifndef ALU_FAST_SHIFT_EN
            cnt_reg    <= cnt_next;
            left_reg   <= left_next;
`endif
        end
    end

    assign bus.ready_o  = (state_reg == IDLE);
    assign bus.valid_o  = (state_reg == DONE);
    assign bus.result_o = result_reg;
    assign bus.zero_o   = zero_reg;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; latency is counted in clock edges after the accept edge.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // Drive one request, scramble the inputs after the accept edge, then wait (bounded) for valid_o.
    task automatic issue(input alu_control_t op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic ready_after);
        @(negedge clk);
        bus.valid_i       = 1'b1;
        bus.alu_control_i = op;
        bus.a_i           = a;
        bus.b_i           = b;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.a_i     = 32'hDEAD_BEEF;
        bus.b_i     = 32'h5A5A_5A5A;
        ready_after = bus.ready_o;
        lat = 0;
        while (!bus.valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("txn op=%0d a=%h b=%h result=%h zero=%0b edges=%0d", op, a, b, bus.result_o, bus.zero_o, lat);
    endtask

    task automatic drain();
        @(negedge clk);
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_o got=%b exp=1", bus.ready_o); end
        checks++;
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid_o got=%b exp=0", bus.valid_o); end
        checks++;
        if (bus.result_o !== 32'h0) begin failures++; $display("FAIL reset_result_o got=%h exp=0", bus.result_o); end
        checks++;
        if (bus.zero_o !== 1'b1) begin failures++; $display("FAIL reset_zero_o got=%b exp=1", bus.zero_o); end
    endtask

    task automatic test_arith();
        int lat; logic rdy;
        issue(ALU_ADD, 32'd7, 32'd5, lat, rdy);
        checks++;
        if (bus.result_o !== 32'd12) begin failures++; $display("FAIL add_result got=%h exp=%h", bus.result_o, 32'd12); end
        checks++;
        if (bus.zero_o !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", bus.zero_o); end
        checks++;
        if (lat != 0) begin failures++; $display("FAIL add_latency got=%0d exp=0", lat); end
        drain();
        issue(ALU_SUB, 32'd5, 32'd5, lat, rdy);
        checks++;
        if (bus.result_o !== 32'd0 || bus.zero_o !== 1'b1) begin
            failures++; $display("FAIL sub_eq got=%h/%b exp=0/1", bus.result_o, bus.zero_o);
        end
        drain();
        issue(ALU_SUB, 32'd0, 32'd1, lat, rdy);
        checks++;
        if (bus.result_o !== 32'hFFFF_FFFF || bus.zero_o !== 1'b0) begin
            failures++; $display("FAIL sub_wrap got=%h/%b exp=ffffffff/0", bus.result_o, bus.zero_o);
        end
        drain();
    endtask

    task automatic test_logic();
        alu_control_t ops [5];
        logic [31:0]  exp [5];
        int lat; logic rdy;
        ops[0] = ALU_XOR; exp[0] = 32'hFF00_5115;
        ops[1] = ALU_OR;  exp[1] = 32'hFFF0_5335;
        ops[2] = ALU_AND; exp[2] = 32'h00F0_0220;
        ops[3] = ALU_A;   exp[3] = 32'hF0F0_1234;
        ops[4] = ALU_B;   exp[4] = 32'h0FF0_4321;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], 32'hF0F0_1234, 32'h0FF0_4321, lat, rdy);
            checks++;
            if (bus.result_o !== exp[i]) begin
                failures++; $display("FAIL logic_op%0d got=%h exp=%h", i, bus.result_o, exp[i]);
            end
            drain();
        end
    endtask

    task automatic test_shift();
        int lat; logic rdy;
        issue(ALU_SLL, 32'd1, 32'h25, lat, rdy);
        checks++;
        if (bus.result_o !== 32'h20) begin failures++; $display("FAIL sll_result got=%h exp=20", bus.result_o); end
        checks++;
        if (lat != (FAST ? 0 : 5)) begin failures++; $display("FAIL sll_latency got=%0d exp=%0d", lat, FAST ? 0 : 5); end
        checks++;
        if (rdy !== 1'b0) begin failures++; $display("FAIL sll_ready_busy got=%b exp=0", rdy); end
        drain();
        issue(ALU_SRL, 32'h8000_0000, 32'd31, lat, rdy);
        checks++;
        if (bus.result_o !== 32'd1) begin failures++; $display("FAIL srl31_result got=%h exp=1", bus.result_o); end
        checks++;
        if (lat != (FAST ? 0 : 31)) begin failures++; $display("FAIL srl31_latency got=%0d exp=%0d", lat, FAST ? 0 : 31); end
        drain();
        issue(ALU_SRL, 32'h0000_ABCD, 32'd32, lat, rdy);
        checks++;
        if (bus.result_o !== 32'h0000_ABCD) begin failures++; $display("FAIL srl0_result got=%h exp=abcd", bus.result_o); end
        checks++;
        if (lat != 0) begin failures++; $display("FAIL srl0_latency got=%0d exp=0", lat); end
        drain();
    endtask

    task automatic test_slt_default();
        int lat; logic rdy;
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, lat, rdy);
        checks++;
        if (bus.result_o !== 32'd1) begin failures++; $display("FAIL slt_neg got=%h exp=1", bus.result_o); end
        drain();
        issue(ALU_SLT, 32'd1, 32'hFFFF_FFFF, lat, rdy);
        checks++;
        if (bus.result_o !== 32'd0 || bus.zero_o !== 1'b1) begin
            failures++; $display("FAIL slt_pos got=%h/%b exp=0/1", bus.result_o, bus.zero_o);
        end
        drain();
        issue(alu_control_t'(4'hF), 32'h1234, 32'h9999, lat, rdy);
        checks++;
        if (bus.result_o !== 32'h1234) begin failures++; $display("FAIL unknown_op got=%h exp=1234", bus.result_o); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat; logic rdy;
        issue(ALU_ADD, 32'd3, 32'd4, lat, rdy);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd7) begin
                failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/7", i, bus.valid_o, bus.result_o);
            end
            checks++;
            if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL bp_no_accept%0d got=%b exp=0", i, bus.ready_o); end
        end
        drain();
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++; $display("FAIL bp_release got=ready%b/valid%b exp=1/0", bus.ready_o, bus.valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic rdy;
        issue(ALU_ADD, 32'd100, 32'd23, lat, rdy);
        drain();
        issue(ALU_SUB, 32'd100, 32'd23, lat, rdy);
        checks++;
        if (bus.result_o !== 32'd77 || lat != 0) begin
            failures++; $display("FAIL b2b_sub got=%h lat=%0d exp=4d lat=0", bus.result_o, lat);
        end
        drain();
    endtask

    task automatic test_reset_mid_shift();
        bit seen_valid;
        @(negedge clk);
        bus.valid_i       = 1'b1;
        bus.alu_control_i = ALU_SLL;
        bus.a_i           = 32'h0000_0003;
        bus.b_i           = 32'd20;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++; $display("FAIL rst_async got=ready%b/valid%b exp=1/0", bus.ready_o, bus.valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin failures++; $display("FAIL rst_shift_valid got=1 exp=0"); end
        checks++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== 32'h0 || bus.zero_o !== 1'b1) begin
            failures++; $display("FAIL rst_shift_after got=%b/%h/%b exp=1/0/1", bus.ready_o, bus.result_o, bus.zero_o);
        end
        $display("txn reset_mid_shift seen_valid=%0b", seen_valid);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        bus.valid_i       = 1'b0;
        bus.ready_i       = 1'b0;
        bus.alu_control_i = ALU_ADD;
        bus.a_i           = '0;
        bus.b_i           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_slt_default();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
